// File: rtl/id_ctrl_unit.sv
// ID-stage control: decodes opcode/funct into the ID/EX control register,
// detects load-use hazards and counts the bubbles they insert.
module id_ctrl_unit #(
  parameter int EXEC_BUS_WIDTH = 6,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [31:0]               i_instr,
  input  logic                      i_flush,
  output logic                      o_stall,
  output logic                      o_valid,
  output logic [EXEC_BUS_WIDTH-1:0] o_execute_bus,
  output logic [MEM_BUS_WIDTH-1:0]  o_memory_bus,
  output logic [WB_BUS_WIDTH-1:0]   o_wb_bus,
  output logic                      o_mux_inst,
  output logic                      o_mux_branch,
  output logic                      o_jump_reg,
  output logic                      o_bne,
  output logic [2:0]                o_ldst_type,
  output logic [REG_ADDR_W-1:0]     o_dst_reg,
  output logic                      o_illegal,
  output logic [CNT_W-1:0]          o_stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_JALR   = 6'b001001;

  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic                  unused_shamt;

  assign opcode       = i_instr[31:26];
  assign funct        = i_instr[5:0];
  assign rs           = i_instr[25:21];
  assign rt           = i_instr[20:16];
  assign rd           = i_instr[15:11];
  assign unused_shamt = ^i_instr[10:6];

  logic [3:0]            alu_op;
  logic                  alu_src, reg_dst, mem_write, mem_read, branch;
  logic                  mem_to_reg, reg_write, mux_inst, mux_branch, jump_reg;
  logic                  is_bne, illegal, is_jal, uses_rs, uses_rt;
  logic [2:0]            ldst;
  logic [REG_ADDR_W-1:0] dst;

  always_comb begin
    alu_op     = 4'b0000;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mux_inst   = 1'b0;
    mux_branch = 1'b0;
    jump_reg   = 1'b0;
    is_bne     = 1'b0;
    ldst       = 3'b000;
    illegal    = 1'b0;
    is_jal     = 1'b0;
    uses_rs    = 1'b1;
    uses_rt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt   = 1'b1;
        reg_write = 1'b1;
        case (funct)
          6'b000000, 6'b000100: alu_op = 4'b0000;
          6'b000010, 6'b000110: alu_op = 4'b0001;
          6'b000011, 6'b000111: alu_op = 4'b0010;
          6'b100001: alu_op = 4'b0011;
          6'b100011: alu_op = 4'b1000;
          6'b100100: alu_op = 4'b0100;
          6'b100101: alu_op = 4'b0101;
          6'b100110: alu_op = 4'b0110;
          6'b100111: alu_op = 4'b0111;
          6'b101010: alu_op = 4'b1001;
          F_JR, F_JALR: begin
            mux_inst   = 1'b1;
            mux_branch = 1'b1;
            jump_reg   = 1'b1;
            reg_write  = funct[0];
          end
          default: begin
            illegal   = 1'b1;
            reg_write = 1'b0;
          end
        endcase
        // shift-by-immediate forms read only rt
        if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
          uses_rs = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        branch  = 1'b1;
        alu_op  = 4'b1000;
        is_bne  = opcode[0];
        uses_rt = 1'b1;
      end
      OP_J, OP_JAL: begin
        mux_inst   = 1'b1;
        mux_branch = 1'b1;
        uses_rs    = 1'b0;
        is_jal     = opcode[0];
        reg_write  = opcode[0];
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100111: begin
        alu_op     = 4'b0011;
        alu_src    = 1'b1;
        reg_dst    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        ldst       = opcode[2:0];
      end
      6'b101000, 6'b101001, 6'b101011: begin
        alu_op    = 4'b0011;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        ldst      = opcode[2:0];
        uses_rt   = 1'b1;
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        alu_src   = 1'b1;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (opcode[2:0])
          3'b000:  alu_op = 4'b0011;
          3'b010:  alu_op = 4'b1001;
          3'b100:  alu_op = 4'b0100;
          3'b101:  alu_op = 4'b0101;
          3'b110:  alu_op = 4'b0110;
          default: alu_op = 4'b1010;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) alu_op = 4'b1111;
  end

  assign dst = !reg_write ? '0 : is_jal ? '1 : reg_dst ? rt : rd;

  // hazard looks at the load currently in ID/EX against this instruction's sources
  assign o_stall = i_valid & ~i_flush & o_valid & o_memory_bus[1] & (o_dst_reg != '0) &
                   (((o_dst_reg == rs) & uses_rs) | ((o_dst_reg == rt) & uses_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid       <= 1'b0;
      o_execute_bus <= '0;
      o_memory_bus  <= '0;
      o_wb_bus      <= '0;
      o_mux_inst    <= 1'b0;
      o_mux_branch  <= 1'b0;
      o_jump_reg    <= 1'b0;
      o_bne         <= 1'b0;
      o_ldst_type   <= 3'b000;
      o_dst_reg     <= '0;
      o_illegal     <= 1'b0;
      o_stall_count <= '0;
    end else begin
      if (o_stall && o_stall_count != '1)
        o_stall_count <= o_stall_count + CNT_W'(1);
      if (i_flush || o_stall || !i_valid) begin
        o_valid       <= 1'b0;
        o_execute_bus <= '0;
        o_memory_bus  <= '0;
        o_wb_bus      <= '0;
        o_mux_inst    <= 1'b0;
        o_mux_branch  <= 1'b0;
        o_jump_reg    <= 1'b0;
        o_bne         <= 1'b0;
        o_ldst_type   <= 3'b000;
        o_dst_reg     <= '0;
        o_illegal     <= 1'b0;
      end else begin
        o_valid       <= 1'b1;
        o_execute_bus <= {reg_dst, alu_src, alu_op};
        o_memory_bus  <= {branch, mem_read, mem_write};
        o_wb_bus      <= {reg_write, mem_to_reg};
        o_mux_inst    <= mux_inst;
        o_mux_branch  <= mux_branch;
        o_jump_reg    <= jump_reg;
        o_bne         <= is_bne;
        o_ldst_type   <= ldst;
        o_dst_reg     <= dst;
        o_illegal     <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_ctrl_unit.sv
// Bench for id_ctrl_unit: decode table, hazard/flush/reset sequences and
// random traffic against an instruction-level reference model.
module tb_id_ctrl_unit;

  typedef struct {
    logic       valid;
    logic [5:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic       mi, mb, jr, bne;
    logic [2:0] ld;
    logic [4:0] dst;
    logic       ill;
  } ctl_t;

  typedef struct {
    logic [31:0] ins;
    logic [24:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_instr = '0;
  logic        i_flush = 1'b0;

  logic        o_stall, o_valid, o_mux_inst, o_mux_branch, o_jump_reg, o_bne, o_illegal;
  logic [5:0]  o_execute_bus;
  logic [2:0]  o_memory_bus, o_ldst_type;
  logic [1:0]  o_wb_bus;
  logic [4:0]  o_dst_reg;
  logic [15:0] o_stall_count;

  logic        s_stall, s_valid, s_mux_inst, s_mux_branch, s_jump_reg, s_bne, s_illegal;
  logic [5:0]  s_execute_bus;
  logic [2:0]  s_memory_bus, s_ldst_type;
  logic [1:0]  s_wb_bus;
  logic [4:0]  s_dst_reg;
  logic [1:0]  s_stall_count;

  id_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_flush(i_flush),
    .o_stall(o_stall), .o_valid(o_valid), .o_execute_bus(o_execute_bus),
    .o_memory_bus(o_memory_bus), .o_wb_bus(o_wb_bus), .o_mux_inst(o_mux_inst),
    .o_mux_branch(o_mux_branch), .o_jump_reg(o_jump_reg), .o_bne(o_bne),
    .o_ldst_type(o_ldst_type), .o_dst_reg(o_dst_reg), .o_illegal(o_illegal),
    .o_stall_count(o_stall_count)
  );

  id_ctrl_unit #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_instr(i_instr), .i_flush(i_flush),
    .o_stall(s_stall), .o_valid(s_valid), .o_execute_bus(s_execute_bus),
    .o_memory_bus(s_memory_bus), .o_wb_bus(s_wb_bus), .o_mux_inst(s_mux_inst),
    .o_mux_branch(s_mux_branch), .o_jump_reg(s_jump_reg), .o_bne(s_bne),
    .o_ldst_type(s_ldst_type), .o_dst_reg(s_dst_reg), .o_illegal(s_illegal),
    .o_stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  ctl_t  m;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  logic  obs_stall;
  vec_t  tbl[16];

  wire [24:0] dut_vec = {o_valid, o_execute_bus, o_memory_bus, o_wb_bus, o_mux_inst,
                         o_mux_branch, o_jump_reg, o_bne, o_ldst_type, o_dst_reg, o_illegal};
  wire [24:0] sat_vec = {s_valid, s_execute_bus, s_memory_bus, s_wb_bus, s_mux_inst,
                         s_mux_branch, s_jump_reg, s_bne, s_ldst_type, s_dst_reg, s_illegal};

  function automatic logic [24:0] pk(ctl_t c);
    return {c.valid, c.ex, c.mem, c.wb, c.mi, c.mb, c.jr, c.bne, c.ld, c.dst, c.ill};
  endfunction

  function automatic logic [24:0] mk(logic [5:0] ex, logic [2:0] mem, logic [1:0] wb,
                                     logic [3:0] jmp, logic [2:0] ld, logic [4:0] dst, logic ill);
    return {1'b1, ex, mem, wb, jmp, ld, dst, ill};
  endfunction

  function automatic logic [31:0] rtype(int fn, int rs, int rt, int rd);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd3, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h1234};
  endfunction

  // reference decode: instruction classes and their effects
  function automatic ctl_t model_dec(logic [31:0] ins);
    ctl_t c;
    int op, fn;
    logic [3:0] alu;
    logic wr, to_rt, imm, ok;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    c = '{default: '0};
    c.valid = 1'b1;
    alu = 4'd0; wr = 1'b0; to_rt = 1'b0; imm = 1'b0; ok = 1'b1;
    if (op == 0) begin
      wr = 1'b1;
      case (fn)
        0, 4: alu = 4'd0;
        2, 6: alu = 4'd1;
        3, 7: alu = 4'd2;
        33: alu = 4'd3;
        35: alu = 4'd8;
        36: alu = 4'd4;
        37: alu = 4'd5;
        38: alu = 4'd6;
        39: alu = 4'd7;
        42: alu = 4'd9;
        8, 9: begin c.mi = 1; c.mb = 1; c.jr = 1; wr = (fn == 9); end
        default: ok = 1'b0;
      endcase
    end else if (op == 4 || op == 5) begin
      alu = 4'd8; c.mem[2] = 1'b1; c.bne = (op == 5);
    end else if (op == 2 || op == 3) begin
      c.mi = 1; c.mb = 1; wr = (op == 3);
    end else if (op inside {32, 33, 35, 36, 37, 39}) begin
      alu = 4'd3; imm = 1; to_rt = 1; wr = 1; c.mem[1] = 1; c.wb[0] = 1; c.ld = 3'(op);
    end else if (op inside {40, 41, 43}) begin
      alu = 4'd3; imm = 1; c.mem[0] = 1; c.ld = 3'(op);
    end else if (op inside {8, 10, 12, 13, 14, 15}) begin
      imm = 1; to_rt = 1; wr = 1;
      case (op)
        8: alu = 4'd3;
        10: alu = 4'd9;
        12: alu = 4'd4;
        13: alu = 4'd5;
        14: alu = 4'd6;
        default: alu = 4'd10;
      endcase
    end else ok = 1'b0;
    if (!ok) begin
      c = '{default: '0};
      c.valid = 1'b1; c.ill = 1'b1; c.ex = 6'b001111;
      return c;
    end
    c.ex = {to_rt, imm, alu};
    c.wb[1] = wr;
    if (wr) c.dst = (op == 3) ? 5'd31 : to_rt ? ins[20:16] : ins[15:11];
    return c;
  endfunction

  function automatic logic model_stall(logic v, logic [31:0] ins, logic fl);
    int op, fn;
    logic urs, urt;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    urs = !(op == 2 || op == 3 || (op == 0 && (fn == 0 || fn == 2 || fn == 3)));
    urt = (op == 0) || op == 4 || op == 5 || op == 40 || op == 41 || op == 43;
    return v && !fl && m.valid && m.mem[1] && m.dst != 0 &&
           ((m.dst == ins[25:21] && urs) || (m.dst == ins[20:16] && urt));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = '0;
    m_cnt2 = '0;
  endtask

  // entered at posedge+1; leaves at next posedge+1
  task automatic cycle(logic v, logic [31:0] ins, logic fl);
    logic p;
    i_valid = v; i_instr = ins; i_flush = fl;
    #4;
    p = model_stall(v, ins, fl);
    obs_stall = o_stall;
    chk("stall", {31'd0, o_stall}, {31'd0, p});
    @(posedge clk);
    if (fl || !v) m = '{default: '0};
    else if (p) begin
      m = '{default: '0};
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_cnt2 != 2'd3) m_cnt2++;
    end else m = model_dec(ins);
    #1;
    chk("idex", {7'd0, dut_vec}, {7'd0, pk(m)});
    chk("count", {16'd0, o_stall_count}, {16'd0, m_cnt});
    chk("count_sat", {30'd0, s_stall_count}, {30'd0, m_cnt2});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] lw8, add98, ins;
    lw8   = itype(35, 1, 8);
    add98 = rtype(33, 8, 3, 9);

    tbl[0]  = '{rtype(33, 1, 2, 3),   mk(6'b000011, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd3, 0)};
    tbl[1]  = '{itype(35, 1, 8),      mk(6'b110011, 3'b010, 2'b11, 4'b0000, 3'd3, 5'd8, 0)};
    tbl[2]  = '{itype(43, 1, 5),      mk(6'b010011, 3'b001, 2'b00, 4'b0000, 3'd3, 5'd0, 0)};
    tbl[3]  = '{itype(4, 1, 2),       mk(6'b001000, 3'b100, 2'b00, 4'b0000, 3'd0, 5'd0, 0)};
    tbl[4]  = '{itype(5, 1, 2),       mk(6'b001000, 3'b100, 2'b00, 4'b0001, 3'd0, 5'd0, 0)};
    tbl[5]  = '{itype(2, 0, 0),       mk(6'b000000, 3'b000, 2'b00, 4'b1100, 3'd0, 5'd0, 0)};
    tbl[6]  = '{itype(3, 0, 0),       mk(6'b000000, 3'b000, 2'b10, 4'b1100, 3'd0, 5'd31, 0)};
    tbl[7]  = '{rtype(8, 4, 0, 0),    mk(6'b000000, 3'b000, 2'b00, 4'b1110, 3'd0, 5'd0, 0)};
    tbl[8]  = '{rtype(9, 4, 0, 7),    mk(6'b000000, 3'b000, 2'b10, 4'b1110, 3'd0, 5'd7, 0)};
    tbl[9]  = '{itype(15, 0, 6),      mk(6'b111010, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd6, 0)};
    tbl[10] = '{rtype(63, 1, 2, 3),   mk(6'b001111, 3'b000, 2'b00, 4'b0000, 3'd0, 5'd0, 1)};
    tbl[11] = '{rtype(3, 0, 2, 9),    mk(6'b000010, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd9, 0)};
    tbl[12] = '{itype(32, 1, 4),      mk(6'b110011, 3'b010, 2'b11, 4'b0000, 3'd0, 5'd4, 0)};
    tbl[13] = '{itype(10, 1, 2),      mk(6'b111001, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd2, 0)};
    tbl[14] = '{itype(63, 1, 2),      mk(6'b001111, 3'b000, 2'b00, 4'b0000, 3'd0, 5'd0, 1)};
    tbl[15] = '{rtype(39, 1, 2, 3),   mk(6'b000111, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd3, 0)};

    // reset holds everything at zero even with a valid lw presented
    model_reset();
    i_valid = 1; i_instr = lw8;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_regs", {7'd0, dut_vec}, 32'd0);
    chk("reset_count", {16'd0, o_stall_count}, 32'd0);
    chk("reset_stall", {31'd0, o_stall}, 32'd0);
    rst_n = 1'b1;
    cycle(1, lw8, 0);
    chk("lw_after_reset", {7'd0, dut_vec}, {7'd0, tbl[1].exp});

    // decode table, idle cycle between entries so no hazard interferes
    for (int i = 0; i < 16; i++) begin
      cycle(1, tbl[i].ins, 0);
      chk($sformatf("table_%0d", i), {7'd0, dut_vec}, {7'd0, tbl[i].exp});
      cycle(0, 32'd0, 0);
    end
    chk("illegal_pulse_gone", {31'd0, o_illegal}, 32'd0);

    // load-use: one stall, bubble, then the add issues
    do_reset();
    cycle(1, lw8, 0);
    cycle(1, add98, 0);
    chk("lu_stall", {31'd0, obs_stall}, 32'd1);
    chk("lu_bubble", {31'd0, o_valid}, 32'd0);
    cycle(1, add98, 0);
    chk("lu_no_restall", {31'd0, obs_stall}, 32'd0);
    chk("lu_issue", {7'd0, dut_vec}, {7'd0, mk(6'b000011, 3'b000, 2'b10, 4'b0000, 3'd0, 5'd9, 0)});
    chk("lu_count", {16'd0, o_stall_count}, 32'd1);

    // no false hazards; shift-by-immediate via rt does stall
    cycle(1, itype(35, 1, 0), 0);
    cycle(1, rtype(33, 0, 0, 9), 0);
    chk("lw0_nostall", {31'd0, obs_stall}, 32'd0);
    cycle(1, lw8, 0);
    cycle(1, {6'd2, 5'd8, 5'd8, 16'h0}, 0);
    chk("j_nostall", {31'd0, obs_stall}, 32'd0);
    cycle(1, lw8, 0);
    cycle(1, rtype(0, 0, 8, 9), 0);
    chk("sll_stall", {31'd0, obs_stall}, 32'd1);
    cycle(1, rtype(0, 0, 8, 9), 0);

    // flush beats a hazard
    cycle(1, lw8, 0);
    cycle(1, add98, 1);
    chk("flush_nostall", {31'd0, obs_stall}, 32'd0);
    chk("flush_bubble", {7'd0, dut_vec}, 32'd0);
    chk("flush_count", {16'd0, o_stall_count}, 32'd2);

    // saturation on the 2-bit counter
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, lw8, 0);
      cycle(1, add98, 0);
      cycle(1, add98, 0);
      if (k == 1) chk("sat_two", {30'd0, s_stall_count}, 32'd2);
    end
    chk("sat_three", {30'd0, s_stall_count}, 32'd3);
    chk("wide_four", {16'd0, o_stall_count}, 32'd4);

    // reset asserted while stalling drops o_stall at once
    cycle(1, lw8, 0);
    i_valid = 1; i_instr = add98; i_flush = 0;
    #3;
    chk("pre_reset_stall", {31'd0, o_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_stall", {31'd0, o_stall}, 32'd0);
    chk("reset_mid_regs", {7'd0, dut_vec}, 32'd0);
    chk("reset_mid_count", {16'd0, o_stall_count}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic with few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      int fns[12] = '{0, 2, 3, 4, 7, 8, 9, 33, 35, 37, 42, 63};
      int ops[20] = '{2, 3, 4, 5, 8, 10, 13, 15, 32, 33, 35, 35, 36, 39, 40, 41, 43, 1, 63, 35};
      if ($urandom_range(0, 9) < 4)
        ins = rtype(fns[$urandom_range(0, 11)], $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
      else
        ins = itype(ops[$urandom_range(0, 19)], $urandom_range(0, 3), $urandom_range(0, 3));
      cycle($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0);
      chk("sat_regs_match", {7'd0, sat_vec}, {7'd0, pk(m)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ctrl_unit.md
Name: id_ctrl_unit

Overview:
- Pipelined successor to the combinational control decoder; sits between the IF/ID register and the EX stage of the MIPS-subset core.
- Decodes opcode/funct, registers all control buses into the ID/EX control register, and detects load-use hazards (stall plus bubble insertion).
- Honours branch/jump flushes from EX, flags illegal instructions, and counts inserted stall bubbles for debug.

Parameters:
- EXEC_BUS_WIDTH, 6, execute bus: [3:0] alu_op, [4] alu_src (1 = immediate operand), [5] reg_dst (1 = rt, 0 = rd).
- MEM_BUS_WIDTH, 3, memory bus: [0] mem_write, [1] mem_read, [2] branch.
- WB_BUS_WIDTH, 2, write-back bus: [0] mem_to_reg, [1] reg_write.
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_instr  in  32  instruction: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
- i_flush  in  1  taken branch/jump from EX; kill the ID instruction.
- o_stall  out  1  combinational; hold PC and IF/ID this cycle.
- o_valid  out  1  ID/EX holds a real instruction.
- o_execute_bus  out  EXEC_BUS_WIDTH  registered.
- o_memory_bus  out  MEM_BUS_WIDTH  registered.
- o_wb_bus  out  WB_BUS_WIDTH  registered.
- o_mux_inst  out  1  registered; 1 = take branch/jump target.
- o_mux_branch  out  1  registered; 1 = jump target, 0 = branch target.
- o_jump_reg  out  1  registered; target comes from rs (jr/jalr).
- o_bne  out  1  registered; branch polarity, 1 = bne.
- o_ldst_type  out  3  registered; opcode[2:0] for loads and stores, else 0.
- o_dst_reg  out  REG_ADDR_W  registered; write register: rd, rt, or 31 for jal.
- o_illegal  out  1  registered; one-cycle flag for an undecodable instruction.
- o_stall_count  out  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (rst_n = 0, asynchronous): every registered output, including o_stall_count, is 0.
- Latency: one cycle from i_instr to the ID/EX outputs.
- A bubble is o_valid = 0 with all buses, flags and o_dst_reg at 0.
- Update priority on each clock edge:
  1. i_flush: load a bubble.
  2. o_stall: load a bubble and increment o_stall_count; the counter saturates at all-ones.
  3. i_valid = 0: load a bubble.
  4. Otherwise: load the decoded instruction with o_valid = 1.
- Hazard condition: o_stall = i_valid & !i_flush & o_valid & o_memory_bus[1] & (o_dst_reg != 0) & ((o_dst_reg == rs & uses_rs) | (o_dst_reg == rt & uses_rt)).
  - uses_rs: every instruction except j, jal and sll/srl/sra.
  - uses_rt: R-type, beq/bne and stores.
  - The stall lasts exactly one cycle, because the bubble clears o_valid.
- R-type (opcode 0): reg_dst = 0, alu_src = 0, reg_write = 1. funct -> alu_op:
  - sll/sllv (000000/000100) -> 0000; srl/srlv (000010/000110) -> 0001; sra/srav (000011/000111) -> 0010.
  - addu 100001 -> 0011; subu 100011 -> 1000; and 100100 -> 0100; or 100101 -> 0101.
  - xor 100110 -> 0110; nor 100111 -> 0111; slt 101010 -> 1001.
  - jr 001000: o_mux_inst = 1, o_mux_branch = 1, o_jump_reg = 1, reg_write = 0.
  - jalr 001001: same as jr but reg_write = 1, o_dst_reg = rd.
  - Any other funct is illegal.
- beq 000100 / bne 000101: branch = 1, alu_op = 1000, alu_src = 0, o_bne = opcode[0], o_mux_inst = 0. EX resolves the branch and drives i_flush.
- j 000010: o_mux_inst = 1, o_mux_branch = 1.
- jal 000011: as j, plus reg_write = 1 and o_dst_reg = 31.
- Loads (100000, 100001, 100011, 100100, 100101, 100111): alu_op = 0011, alu_src = 1, reg_dst = 1, mem_read = 1, mem_to_reg = 1, reg_write = 1.
- Stores (101000, 101001, 101011): alu_op = 0011, alu_src = 1, mem_write = 1, reg_write = 0, o_dst_reg = 0.
- Immediates: alu_src = 1, reg_dst = 1, reg_write = 1. Opcode -> alu_op:
  - addi 001000 -> 0011; slti 001010 -> 1001; andi 001100 -> 0100; ori 001101 -> 0101; xori 001110 -> 0110; lui 001111 -> 1010.
- Illegal instruction: o_illegal = 1, alu_op = 1111, o_valid = 1, all write/memory/jump controls 0.
- Simultaneous i_flush and hazard: flush wins, o_stall = 0, and the counter does not increment.
- Reset mid-stall: everything clears and o_stall drops in the same cycle.

Test Plan:
- Reset: hold rst_n = 0 and drive a valid lw -> all outputs 0. Release rst_n -> decoded lw appears one clock later.
- Decode table: sweep every legal opcode/funct -> next-cycle buses match the table, e.g. addu gives exec 000011 and wb 10; lw rt = 8 gives exec 110011, mem 010, wb 11, dst 8.
- Load-use: lw $8 then add $9,$8,$3 -> o_stall = 1 for one cycle, a bubble in ID/EX, add issued on the following cycle, o_stall_count = 1.
- No false hazard: lw $0 then add using $0 -> no stall. lw $8 then j -> no stall. lw $8 then sll $9,$8 -> stall.
- Flush priority: hazard condition present together with i_flush = 1 -> o_stall = 0, bubble loaded, counter unchanged.
- Illegal and saturation: funct 111111 -> o_illegal pulses one cycle with alu_op 1111. With CNT_W = 2, four hazards -> o_stall_count stays at 3.
